// File: rtl/test_udiv_64ns_33ns_32_seq.sv
// Sequential radix-2 restoring unsigned divider, one quotient bit per clock.
// Valid/ready on both sides; one division in flight at a time.
module test_udiv_64ns_33ns_32_seq #(
    parameter int ID         = 1,
    parameter int DIVIDEND_W = 64,
    parameter int DIVISOR_W  = 33,
    parameter int QUOT_W     = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  ovf
);

    localparam int R_W   = DIVISOR_W + 1;
    localparam int CNT_W = $clog2(QUOT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [R_W-1:0]        r_q, r_d;
    logic [QUOT_W-1:0]     q_q, q_d;
    logic [DIVISOR_W-1:0]  d_q, d_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [QUOT_W-1:0]     quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  ovf_q, ovf_d;

    logic [R_W-1:0]        hi_ext;
    logic [R_W-1:0]        div_ext;
    logic                  hi_ovf;
    logic [R_W:0]          trial;
    logic [R_W:0]          dd_ext;
    logic [R_W:0]          diff;
    logic                  fits;
    logic [R_W-1:0]        r_step;
    logic [QUOT_W-1:0]     q_step;
    logic                  last;

    // Upper dividend half must be below the divisor, else the quotient overflows.
    assign hi_ext  = R_W'(dividend >> QUOT_W);
    assign div_ext = {1'b0, divisor};
    assign hi_ovf  = hi_ext >= div_ext;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    assign trial  = {r_q, q_q[QUOT_W-1]};
    assign dd_ext = {2'b00, d_q};
    assign diff   = trial - dd_ext;
    assign fits   = trial >= dd_ext;
    assign r_step = R_W'(fits ? diff : trial);
    assign q_step = {q_q[QUOT_W-2:0], fits};
    assign last   = cnt_q == CNT_W'(QUOT_W - 1);

    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign ovf       = ovf_q;

    // Control state sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = hi_ovf ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        ovf_d  = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (hi_ovf) begin
                        quot_d = '1;
                        rem_d  = '0;
                        ovf_d  = 1'b1;
                    end else begin
                        r_d   = hi_ext;
                        q_d   = dividend[QUOT_W-1:0];
                        d_d   = divisor;
                        cnt_d = '0;
                    end
                end
            end
            S_CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    quot_d = q_step;
                    rem_d  = r_step[DIVISOR_W-1:0];
                    ovf_d  = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
